// File: rtl/wb_port_arbiter_pkg.sv
// Shared state codes and select encodings for the regfile write-port arbiter.
// The spare state code 2'b11 is never entered and recovers to IDLE.
package wb_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      DRAIN = 2'b10
   } arb_state_t;

   localparam logic SEL_PIPE = 1'b0;
   localparam logic SEL_MD   = 1'b1;

   // Starvation counter only needs to reach STARVE_MAX-1; keep at least one bit.
   function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
      return (starve_max < 2) ? 1 : $clog2(starve_max + 1);
   endfunction

endpackage

// File: rtl/wb_port_arbiter_mux32.sv
// Two-input write-data mux feeding the regfile: in1 = pipeline, in2 = md buffer.
module wb_port_arbiter_mux32
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic              sel,
   output logic [DATA_W-1:0] y
);

   assign y = (sel == SEL_MD) ? in2 : in1;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and the mul/div unit.
// The pipeline wins; a buffered md result is force-drained after STARVE_MAX lost cycles.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              md_valid,
   input  logic [ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              wb_sel,
   output logic              pipe_stall
);

   localparam int unsigned CNT_W = starve_cnt_width(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

   arb_state_t        state;
   logic [CNT_W-1:0]  starve_cnt;
   logic [ADDR_W-1:0] held_addr;
   logic [DATA_W-1:0] held_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         held_addr  <= '0;
         held_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (md_valid) begin
                  held_addr  <= md_addr;
                  held_data  <= md_data;
                  starve_cnt <= '0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (!pipe_we) begin
                  starve_cnt <= '0;
                  state      <= IDLE;
               end else if (starve_cnt == CNT_LAST) begin
                  state      <= DRAIN;
               end else begin
                  starve_cnt <= starve_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               starve_cnt <= '0;
               state      <= IDLE;
            end
            default: begin
               starve_cnt <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign md_ready   = (state == IDLE);
   assign pipe_stall = (state == DRAIN);

   // Port goes to the buffer whenever WB is idle or the drain is being forced.
   always_comb begin
      wb_sel = SEL_PIPE;
      case (state)
         WAIT:    wb_sel = pipe_we ? SEL_PIPE : SEL_MD;
         DRAIN:   wb_sel = SEL_MD;
         default: wb_sel = SEL_PIPE;
      endcase
   end

   assign rf_we   = (wb_sel == SEL_MD) | pipe_we;
   assign rf_addr = (wb_sel == SEL_MD) ? held_addr : pipe_addr;

   wb_port_arbiter_mux32 #(
      .DATA_W (DATA_W)
   ) u_mux32 (
      .in1 (pipe_data),
      .in2 (held_data),
      .sel (wb_sel),
      .y   (rf_data)
   );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised bench for wb_port_arbiter against a lost-cycle counting reference model,
// with directed reset, free-port, starvation and mid-operation reset scenarios.
module tb_wb_port_arbiter;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int STARVE_MAX = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_data;
   logic              md_valid;
   logic [ADDR_W-1:0] md_addr;
   logic [DATA_W-1:0] md_data;
   logic              md_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              wb_sel;
   logic              pipe_stall;

   wb_port_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_we    (pipe_we),
      .pipe_addr  (pipe_addr),
      .pipe_data  (pipe_data),
      .md_valid   (md_valid),
      .md_addr    (md_addr),
      .md_data    (md_data),
      .md_ready   (md_ready),
      .rf_we      (rf_we),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .wb_sel     (wb_sel),
      .pipe_stall (pipe_stall)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: buffered result, count of cycles it has lost, forced-drain flag.
   bit                m_full;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   int                m_lost;
   bit                m_drain;
   int                cyc;
   logic [ADDR_W+DATA_W-1:0] acc_q[$];
   int                acc_t[$];
   bit                md_hold;
   bit                pipe_hold;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_full    = 1'b0;
      m_lost    = 0;
      m_drain   = 1'b0;
      md_hold   = 1'b0;
      pipe_hold = 1'b0;
      acc_q.delete();
      acc_t.delete();
   endtask

   // Compare DUT outputs for the current cycle, then advance the model past the next edge.
   task automatic step_check();
      bit                e_md;
      bit                e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      logic [ADDR_W+DATA_W-1:0] ent;
      int                t;
      e_md   = m_drain || (m_full && !pipe_we);
      e_we   = e_md || pipe_we;
      e_addr = e_md ? m_addr : pipe_addr;
      e_data = e_md ? m_data : pipe_data;
      check_eq("md_ready", 32'(md_ready), 32'(!m_full));
      check_eq("pipe_stall", 32'(pipe_stall), 32'(m_drain));
      check_eq("wb_sel", 32'(wb_sel), 32'(e_md));
      check_eq("rf_we", 32'(rf_we), 32'(e_we));
      if (e_we) begin
         check_eq("rf_addr", 32'(rf_addr), 32'(e_addr));
         check_eq("rf_data", rf_data, e_data);
      end
      // Independent order/latency check of md writes against the acceptance log.
      if (rf_we && wb_sel) begin
         check_eq("md_write_expected", 32'(acc_q.size() > 0), 32'd1);
         if (acc_q.size() > 0) begin
            ent = acc_q.pop_front();
            t   = acc_t.pop_front();
            check_eq("md_order_addr", 32'(rf_addr), 32'(ent[ADDR_W+DATA_W-1:DATA_W]));
            check_eq("md_order_data", rf_data, ent[DATA_W-1:0]);
            check_eq("md_latency", 32'((cyc - t >= 1) && (cyc - t <= STARVE_MAX + 1)), 32'd1);
         end
      end
      pipe_hold = m_drain && pipe_we;
      md_hold   = md_valid && m_full;
      if (!m_full) begin
         if (md_valid) begin
            m_full = 1'b1;
            m_addr = md_addr;
            m_data = md_data;
            m_lost = 0;
            acc_q.push_back({md_addr, md_data});
            acc_t.push_back(cyc);
         end
      end else if (e_md) begin
         m_full  = 1'b0;
         m_drain = 1'b0;
         m_lost  = 0;
      end else begin
         m_lost++;
         if (m_lost == STARVE_MAX) m_drain = 1'b1;
      end
      cyc++;
   endtask

   task automatic cycle(input logic we, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
      @(negedge clk);
      pipe_we   = we;
      pipe_addr = pa;
      pipe_data = pd;
      md_valid  = mv;
      md_addr   = ma;
      md_data   = md;
      #1;
      step_check();
   endtask

   task automatic rand_cycle(input int pipe_pct);
      @(negedge clk);
      if (!pipe_hold) begin
         pipe_we   = ($urandom_range(0, 99) < pipe_pct);
         pipe_addr = ADDR_W'($urandom);
         pipe_data = $urandom;
      end
      if (!md_hold) begin
         md_valid = ($urandom_range(0, 2) == 0);
         md_addr  = ADDR_W'($urandom);
         md_data  = $urandom;
      end
      #1;
      step_check();
   endtask

   initial begin
      cyc = 0;
      model_reset();
      // Reset outputs with a live pipeline request.
      rst_n     = 1'b0;
      pipe_we   = 1'b1;
      pipe_addr = 5'd5;
      pipe_data = 32'h1234_5678;
      md_valid  = 1'b0;
      md_addr   = '0;
      md_data   = '0;
      #2;
      check_eq("rst_md_ready", 32'(md_ready), 32'd1);
      check_eq("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      check_eq("rst_wb_sel", 32'(wb_sel), 32'd0);
      check_eq("rst_rf_we", 32'(rf_we), 32'd1);
      check_eq("rst_rf_addr", 32'(rf_addr), 32'd5);
      @(negedge clk);
      rst_n = 1'b1;

      // Free port: md result written the cycle after acceptance.
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hDEAD_BEEF);
      check_eq("free_no_same_cycle", 32'(wb_sel), 32'd0);
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("free_wb_sel", 32'(wb_sel), 32'd1);
      check_eq("free_rf_addr", 32'(rf_addr), 32'd8);
      check_eq("free_rf_data", rf_data, 32'hDEAD_BEEF);
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("free_ready_again", 32'(md_ready), 32'd1);

      // Starvation: three lost cycles, then a one-cycle forced drain.
      cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hCAFE_0009);
      for (int i = 0; i < STARVE_MAX; i++) begin
         cycle(1'b1, 5'(2 + i), 32'(32'h20 + i), 1'b0, 5'd0, 32'h0);
         check_eq("starve_pipe_wins", 32'(wb_sel), 32'd0);
      end
      cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
      check_eq("starve_stall", 32'(pipe_stall), 32'd1);
      check_eq("starve_md_addr", 32'(rf_addr), 32'd9);
      cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
      check_eq("starve_reissue_addr", 32'(rf_addr), 32'd7);
      check_eq("starve_unstalled", 32'(pipe_stall), 32'd0);

      // Gap after two pipe writes: md written on the third cycle without a stall.
      cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0A0_0010);
      cycle(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("gap_md_write", 32'(rf_addr), 32'd10);
      check_eq("gap_no_stall", 32'(pipe_stall), 32'd0);

      // Reset while the buffer is full: the result is dropped.
      cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hBAD0_0012);
      cycle(1'b1, 5'd6, 32'h67, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      pipe_we  = 1'b0;
      md_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("midrst_md_ready", 32'(md_ready), 32'd1);
      check_eq("midrst_wb_sel", 32'(wb_sel), 32'd0);
      check_eq("midrst_rf_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      end

      // Randomised traffic at increasing pipeline load.
      for (int i = 0; i < 400; i++) rand_cycle(30);
      for (int i = 0; i < 400; i++) rand_cycle(75);
      for (int i = 0; i < 400; i++) rand_cycle(97);
      md_hold = 1'b0;
      for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_eq("all_md_written", 32'(acc_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
